// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one fixed-latency data-memory port between the CPU MEM
// stage and a debug/loader master. At most one transaction is in flight. It is
// issued in ISSUE, waits MEM_LAT cycles in WAIT, and is answered in RESP.
// Build option: define DMEM_ARB_RR_EN to use round-robin arbitration when both
// requesters are pending. When it is undefined, the CPU has fixed priority and
// DBG is forced to win after STARVE_MAX consecutive losses.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    // CPU (pipeline MEM stage)
    input  logic                i_cpu_req,
    input  logic                i_cpu_wren,
    input  logic [ADDR_W-1:0]   i_cpu_addr,
    input  logic [DATA_W-1:0]   i_cpu_wdata,
    input  logic [DATA_W/8-1:0] i_cpu_be,
    output logic                o_cpu_gnt,
    output logic                o_cpu_rvalid,
    output logic [DATA_W-1:0]   o_cpu_rdata,
    output logic                o_cpu_stall,
    // DBG (debug / loader master)
    input  logic                i_dbg_req,
    input  logic                i_dbg_wren,
    input  logic [ADDR_W-1:0]   i_dbg_addr,
    input  logic [DATA_W-1:0]   i_dbg_wdata,
    input  logic [DATA_W/8-1:0] i_dbg_be,
    output logic                o_dbg_gnt,
    output logic                o_dbg_rvalid,
    output logic [DATA_W-1:0]   o_dbg_rdata,
    // Memory port
    output logic                o_mem_req,
    output logic                o_mem_wren,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    state_e            state_q;
    owner_e            owner_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              wren_q;
    logic              cpu_rvalid_q;
    logic              dbg_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

`ifndef DMEM_ARB_RR_EN
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    logic [STV_W-1:0] starve_cnt_q;
    logic [STV_W-1:0] starve_cnt_d;
`endif

    logic   any_req;
    logic   pick_dbg;
    owner_e pick_owner;
    logic   issue_live;

    assign any_req    = i_cpu_req | i_dbg_req;
    assign pick_owner = pick_dbg ? OWN_DBG : OWN_CPU;

    // Arbitration winner (and starvation counter update) for an IDLE/RESP decision.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        pick_dbg = i_dbg_req;
`ifdef DMEM_ARB_RR_EN
        if (i_cpu_req && i_dbg_req) begin
            pick_dbg = (owner_q == OWN_CPU);
        end
`else
        starve_cnt_d = starve_cnt_q;
        if (i_cpu_req && i_dbg_req) begin
            pick_dbg = (starve_cnt_q == STV_W'(STARVE_MAX));
        end
        if (pick_dbg) begin
            starve_cnt_d = '0;
        end else if (i_dbg_req && (starve_cnt_q != STV_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
`endif
    end

    // Issue stage: pass the owner's request fields straight to memory, unless the owner has withdrawn.
    always_comb begin
        issue_live  = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_wren  = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = '0;
        if (state_q == S_ISSUE) begin
            if (owner_q == OWN_CPU) begin
                issue_live = i_cpu_req;
                if (i_cpu_req) begin
                    o_mem_wren  = i_cpu_wren;
                    o_mem_addr  = i_cpu_addr;
                    o_mem_wdata = i_cpu_wdata;
                    o_mem_be    = i_cpu_be;
                end
            end else begin
                issue_live = i_dbg_req;
                if (i_dbg_req) begin
                    o_mem_wren  = i_dbg_wren;
                    o_mem_addr  = i_dbg_addr;
                    o_mem_wdata = i_dbg_wdata;
                    o_mem_be    = i_dbg_be;
                end
            end
            o_mem_req = issue_live;
        end
    end

    assign o_cpu_gnt    = issue_live && (owner_q == OWN_CPU);
    assign o_dbg_gnt    = issue_live && (owner_q == OWN_DBG);
    assign o_cpu_rvalid = cpu_rvalid_q;
    assign o_dbg_rvalid = dbg_rvalid_q;
    assign o_cpu_rdata  = cpu_rdata_q;
    assign o_dbg_rdata  = dbg_rdata_q;
    // The stall is forced low while reset is asserted, so every output is 0 during reset.
    assign o_cpu_stall  = i_rst & i_cpu_req & ~cpu_rvalid_q;

    // Transaction sequencer: IDLE -> ISSUE -> WAIT x MEM_LAT -> RESP, with registered responses.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_CPU;
            wait_cnt_q   <= '0;
            wren_q       <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
`ifndef DMEM_ARB_RR_EN
            starve_cnt_q <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_RESP: begin
                    if (any_req) begin
                        state_q <= S_ISSUE;
                        owner_q <= pick_owner;
`ifndef DMEM_ARB_RR_EN
                        starve_cnt_q <= starve_cnt_d;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (issue_live) begin
                        wren_q     <= o_mem_wren;
                        wait_cnt_q <= CNT_W'(MEM_LAT - 1);
                        state_q    <= S_WAIT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= S_RESP;
                        if (owner_q == OWN_CPU) begin
                            cpu_rvalid_q <= 1'b1;
                            cpu_rdata_q  <= wren_q ? '0 : i_mem_rdata;
                        end else begin
                            dbg_rvalid_q <= 1'b1;
                            dbg_rdata_q  <= wren_q ? '0 : i_mem_rdata;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
